dac_channel: RTL and testbench
==============================

DAC_CHANNEL -- requirements
Module: dac_channel

Interface
REQ-001 Parameter UNDERRUN_TIMEOUT, default 1000: idle cycles without valid_in while running before an underrun is declared.
REQ-002 Parameter STRETCH, default 10000000: cycles underrun_out stays high after an underrun event.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 penable, psel, pwrite  input  1 each  APB control.
REQ-006 paddr  input  32  APB address; only paddr[7:0] decoded.
REQ-007 pwdata  input  32  APB write data.
REQ-008 prdata  output  32  APB read data.
REQ-009 in  input  8  signed two's-complement sample from the TX datapath.
REQ-010 valid_in  input  1  qualifies in, one sample per high cycle.
REQ-011 out  output  8  signed sample to DAC, registered.
REQ-012 valid_out  output  1  qualifies out, registered.
REQ-013 underrun_out  output  1  stretched underrun indicator.
REQ-014 led  output  3  register-driven LED outputs.

Function
REQ-015 APB write on psel & penable & pwrite; read data combinational from paddr[7:0] when psel; unmapped addresses read 0, writes ignored.
REQ-016 Map: 0x00 CTRL {bit0 enable, bit1 src_sel (0 stream, 1 constant), bit2 stat_clear (self-clearing, reads 0)}; 0x04 GAIN[15:0] signed Q8.8; 0x08 OFFSET[7:0] signed; 0x0C CONST[7:0] signed; 0x10 STATUS {bit0 underrun_sticky, bit1 clip_sticky} W1C; 0x14 SAMPLE_COUNT[31:0] RO; 0x18 LED[2:0].
REQ-017 Source sample: in when src_sel=0; CONST when src_sel=1, with an internal valid every cycle.
REQ-018 Stage 1: 9-bit signed sum = source + OFFSET (no wrap).
REQ-019 Stage 2: 25-bit signed product = stage1 sum x GAIN.
REQ-020 Stage 3: saturate product[24:8] to [-128,127] into out; clip_sticky set when saturation occurs.
REQ-021 Latency valid_in to valid_out = exactly 3 cycles; valid propagates unchanged through stages; back-to-back samples every cycle accepted.
REQ-022 enable=0: pipeline valids forced 0, out held at 0, valid_out 0 from the next cycle.
REQ-023 State machine IDLE/RUN/UNDERRUN; IDLE whenever enable=0 (from any state, next cycle).
REQ-024 IDLE->RUN on enable=1 and first qualified source sample; src_sel=1 enters RUN immediately.
REQ-025 RUN: gap counter reset on each valid_in, increments otherwise; at UNDERRUN_TIMEOUT -> UNDERRUN, set underrun_sticky, load stretch counter with STRETCH.
REQ-026 UNDERRUN -> RUN on next valid_in; that sample processed normally.
REQ-027 underrun_out = (stretch counter != 0); counter decrements to 0; reloads on a new underrun.
REQ-028 SAMPLE_COUNT increments on each valid_out, saturates at 0xFFFFFFFF, cleared by stat_clear; stat_clear and increment same cycle -> 0.
REQ-029 Sticky set and W1C same cycle: set wins.
REQ-030 GAIN/OFFSET changes take effect on the next sample entering stage 1; in-flight samples use captured values.

Reset
REQ-031 Reset values: CTRL 0, GAIN 0x0100, OFFSET 0, CONST 0, STATUS 0, SAMPLE_COUNT 0, LED 0, state IDLE, counters 0, out 0, valid_out 0, underrun_out 0.
REQ-032 Reset mid-stream discards in-flight samples; no valid_out after reset deasserts until a new sample completes 3 cycles.

Verification
REQ-033 enable=1, GAIN 0x0100, OFFSET 0, in=0x10 valid one cycle -> out=0x10, valid_out 3 cycles later; SAMPLE_COUNT=1.
REQ-034 GAIN 0x0400, in=0x40 -> out=0x7F, clip_sticky=1; in=0xC0 -> out=0x80.
REQ-035 OFFSET 0x7F, GAIN 0x0100, in=0x7F -> sum 254 no wrap -> out=0x7F, clip set.
REQ-036 UNDERRUN_TIMEOUT=8, STRETCH=20: one sample then 8 idle cycles -> underrun_sticky=1, underrun_out high 20 cycles; next valid_in returns RUN.
REQ-037 src_sel=1, CONST 0xF0, enable=1 -> continuous valid_out, out=0xF0; enable=0 -> valid_out 0, out 0 next cycle.
REQ-038 Assert reset with 3 samples in flight -> outputs zero immediately, registers at reset values.

Source files
------------

// File: rtl/dac_channel_if.sv
// dac_channel_if
//   APB-style register bus for dac_channel.
//   psel/penable/pwrite : transfer control (master -> slave)
//   paddr/pwdata        : address and write data (master -> slave)
//   prdata              : read data, combinational from the slave
interface dac_channel_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/dac_channel.sv
// dac_channel
//   Sample conditioning for one DAC lane: source select, offset, Q8.8 gain,
//   saturation, underrun supervision and a small APB register file.
//   clk, reset        : single clock, asynchronous active-high reset
//   apb (slave)       : register access, paddr[7:0] decoded
//   in / valid_in     : signed stream sample and its qualifier
//   out / valid_out   : registered signed DAC sample, 3 cycles after its input
//   underrun_out      : stretched underrun indicator
//   led               : register-driven LEDs
//
//   state     | meaning
//   ST_IDLE   | channel disabled or waiting for the first sample
//   ST_RUN    | samples arriving, gap counter watching for starvation
//   ST_UNDERRUN | gap exceeded the timeout, waiting for the next sample
module dac_channel #(
  parameter int UNDERRUN_TIMEOUT = 1000,
  parameter int STRETCH          = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  dac_channel_if.slave      apb,
  input  logic [7:0]        in,
  input  logic              valid_in,
  output logic [7:0]        out,
  output logic              valid_out,
  output logic              underrun_out,
  output logic [2:0]        led
);

  localparam int GW = $clog2(UNDERRUN_TIMEOUT + 1);
  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(UNDERRUN_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_UNDERRUN} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] stretch_cnt;
  logic          gap_clr, gap_inc, underrun_evt;

  logic        enable, src_sel;
  logic [15:0] gain;
  logic [7:0]  offset, const_val;
  logic        underrun_sticky, clip_sticky;
  logic [31:0] sample_count;

  logic        wr_en, stat_clear;
  logic [7:0]  addr;
  logic [31:0] rdata;

  logic        src_valid;
  logic [7:0]  src_data;
  logic        s1_valid, s2_valid;
  logic [8:0]  s1_sum;
  logic [15:0] s1_gain;
  logic [24:0] s2_prod;
  logic [16:0] prod_hi;
  logic        sat_pos, sat_neg, clip_evt;
  logic        unused_bits;

  assign addr       = apb.paddr[7:0];
  assign wr_en      = apb.psel & apb.penable & apb.pwrite;
  // stat_clear has no storage: it is a one-cycle strobe and always reads 0
  assign stat_clear = wr_en && (addr == 8'h00) && apb.pwdata[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable    <= 1'b0;
      src_sel   <= 1'b0;
      gain      <= 16'h0100;
      offset    <= 8'h00;
      const_val <= 8'h00;
      led       <= 3'b000;
    end else if (wr_en) begin
      case (addr)
        8'h00: begin
          enable  <= apb.pwdata[0];
          src_sel <= apb.pwdata[1];
        end
        8'h04:   gain      <= apb.pwdata[15:0];
        8'h08:   offset    <= apb.pwdata[7:0];
        8'h0C:   const_val <= apb.pwdata[7:0];
        8'h18:   led       <= apb.pwdata[2:0];
        default: ;
      endcase
    end
  end

  // a new event in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_sticky <= 1'b0;
      clip_sticky     <= 1'b0;
      sample_count    <= 32'd0;
    end else begin
      underrun_sticky <= underrun_evt |
                         (underrun_sticky & ~(wr_en && addr == 8'h10 && apb.pwdata[0]));
      clip_sticky     <= clip_evt |
                         (clip_sticky & ~(wr_en && addr == 8'h10 && apb.pwdata[1]));
      if (stat_clear)
        sample_count <= 32'd0;
      else if (enable && s2_valid && sample_count != 32'hFFFF_FFFF)
        sample_count <= sample_count + 32'd1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (apb.psel) begin
      case (addr)
        8'h00:   rdata = {30'd0, src_sel, enable};
        8'h04:   rdata = {16'd0, gain};
        8'h08:   rdata = {24'd0, offset};
        8'h0C:   rdata = {24'd0, const_val};
        8'h10:   rdata = {30'd0, clip_sticky, underrun_sticky};
        8'h14:   rdata = sample_count;
        8'h18:   rdata = {29'd0, led};
        default: rdata = 32'd0;
      endcase
    end
  end
  assign apb.prdata = rdata;

  assign src_valid = enable & (src_sel | valid_in);
  assign src_data  = src_sel ? const_val : in;

  // product of sign-extended operands: the low 25 bits are the exact signed result
  assign prod_hi  = s2_prod[24:8];
  assign sat_pos  = ~prod_hi[16] & (|prod_hi[15:7]);
  assign sat_neg  = prod_hi[16] & ~(&prod_hi[15:7]);
  assign clip_evt = enable & s2_valid & (sat_pos | sat_neg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      out       <= 8'h00;
      s1_sum    <= 9'd0;
      s1_gain   <= 16'd0;
      s2_prod   <= 25'd0;
    end else if (!enable) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      out       <= 8'h00;
    end else begin
      s1_valid <= src_valid;
      if (src_valid) begin
        s1_sum  <= {src_data[7], src_data} + {offset[7], offset};
        s1_gain <= gain;
      end
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_prod <= {{16{s1_sum[8]}}, s1_sum} * {{9{s1_gain[15]}}, s1_gain};
      valid_out <= s2_valid;
      if (s2_valid)
        out <= sat_pos ? 8'h7F : (sat_neg ? 8'h80 : prod_hi[7:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      gap_cnt     <= '0;
      stretch_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (gap_clr)
        gap_cnt <= '0;
      else if (gap_inc)
        gap_cnt <= gap_cnt + GW'(1);
      if (underrun_evt)
        stretch_cnt <= SW'(STRETCH);
      else if (stretch_cnt != '0)
        stretch_cnt <= stretch_cnt - SW'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    gap_clr      = 1'b0;
    gap_inc      = 1'b0;
    underrun_evt = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
      gap_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          gap_clr = 1'b1;
          if (src_valid) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (src_valid) begin
            gap_clr = 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            state_nxt    = ST_UNDERRUN;
            underrun_evt = 1'b1;
            gap_clr      = 1'b1;
          end else begin
            gap_inc = 1'b1;
          end
        end
        ST_UNDERRUN: begin
          gap_clr = 1'b1;
          if (src_valid) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign underrun_out = (stretch_cnt != '0);

  assign unused_bits = ^{apb.paddr[31:8], apb.pwdata[31:16], s2_prod[7:0]};

endmodule

// File: tb/tb_dac_channel.sv
module tb_dac_channel;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       valid_in;
  logic [7:0] out;
  logic       valid_out;
  logic       underrun_out;
  logic [2:0] led;

  int total = 0;
  int bad   = 0;
  int exp_count;
  bit exp_clip;

  always #5 clk = ~clk;

  dac_channel_if apb ();

  dac_channel #(.UNDERRUN_TIMEOUT(8), .STRETCH(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .apb          (apb),
    .in           (din),
    .valid_in     (valid_in),
    .out          (out),
    .valid_out    (valid_out),
    .underrun_out (underrun_out),
    .led          (led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference: (source + offset) * gain in Q8.8, floor-shifted, then clamped
  function automatic int scale(input logic [7:0] x, input logic [7:0] off, input logic [15:0] g);
    int s;
    s = int'($signed(x)) + int'($signed(off));
    return (s * int'($signed(g))) >>> 8;
  endfunction

  function automatic logic [7:0] clamp8(input int q);
    if (q > 127) return 8'h7F;
    if (q < -128) return 8'h80;
    return 8'(q);
  endfunction

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
    apb.paddr = {24'd0, a}; apb.pwdata = d;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0;
    apb.paddr = {24'd0, a};
    @(negedge clk);
    apb.penable = 1'b1;
    #1 d = apb.prdata;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic send_chk(input string tag, input logic [7:0] d, input logic [7:0] exp);
    int lat;
    lat = 0;
    @(negedge clk);
    din = d; valid_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (valid_out === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_out"}, out, exp);
  endtask

  // one sample, then silence: watch the output and the underrun pulse
  task automatic probe(input string tag, input logic [7:0] d);
    int first, highs;
    first = 0; highs = 0;
    @(negedge clk);
    din = d; valid_in = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (c == 3) begin
        chk({tag, "_valid"}, valid_out, 1);
        chk({tag, "_out"}, out, d);
      end
      if (underrun_out === 1'b1) begin
        if (first == 0) first = c;
        highs++;
      end
    end
    chk({tag, "_underrun_start"}, first, 9);
    chk({tag, "_underrun_len"}, highs, 20);
  endtask

  task automatic stream_round(input int n, input logic [15:0] g, input logic [7:0] off);
    logic       hv [3];
    logic [7:0] hd [3];
    logic [7:0] x;
    bit         v;
    int         q;
    apb_wr(8'h04, {16'd0, g});
    apb_wr(8'h08, {24'd0, off});
    for (int k = 0; k < 3; k++) begin
      hv[k] = 1'b0; hd[k] = 8'h00;
    end
    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      chk("rnd_valid", valid_out, hv[2]);
      if (hv[2]) chk("rnd_out", out, hd[2]);
      hv[2] = hv[1]; hd[2] = hd[1];
      hv[1] = hv[0]; hd[1] = hd[0];
      v = (i < n) && ($urandom_range(0, 9) < 7);
      x = 8'($urandom);
      din = x; valid_in = v;
      q = scale(x, off, g);
      hv[0] = v; hd[0] = clamp8(q);
      if (v) begin
        exp_count++;
        if (q > 127 || q < -128) exp_clip = 1'b1;
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    reset = 1'b1; din = 8'h00; valid_in = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 32'd0; apb.pwdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_underrun_out", underrun_out, 0);
    chk("rst_led", led, 0);
    reset = 1'b0;
    chk_rd("rst_ctrl", 8'h00, 0);
    chk_rd("rst_gain", 8'h04, 32'h100);
    chk_rd("rst_offset", 8'h08, 0);
    chk_rd("rst_const", 8'h0C, 0);
    chk_rd("rst_status", 8'h10, 0);
    chk_rd("rst_count", 8'h14, 0);
    chk_rd("rst_ledreg", 8'h18, 0);
    chk("prdata_idle", apb.prdata, 0);

    // unity gain, single sample
    apb_wr(8'h00, 32'h1);
    send_chk("unity", 8'h10, 8'h10);
    chk_rd("count_one", 8'h14, 1);

    // gain 4.0 saturates both ways
    apb_wr(8'h04, 32'h400);
    send_chk("gain4_pos", 8'h40, 8'h7F);
    apb_rd(8'h10, rd);
    chk("clip_set_pos", rd & 32'h2, 32'h2);
    send_chk("gain4_neg", 8'hC0, 8'h80);
    apb_wr(8'h10, 32'h2);
    apb_rd(8'h10, rd);
    chk("clip_w1c", rd & 32'h2, 0);

    // offset sum beyond 8 bits must not wrap
    apb_wr(8'h04, 32'h100);
    apb_wr(8'h08, 32'h7F);
    send_chk("offset_nowrap", 8'h7F, 8'h7F);
    apb_rd(8'h10, rd);
    chk("clip_set_offset", rd & 32'h2, 32'h2);
    apb_wr(8'h08, 32'h0);

    // underrun detection, stretch and recovery
    apb_wr(8'h00, 32'h0);
    repeat (30) @(negedge clk);
    apb_wr(8'h10, 32'h3);
    chk("underrun_quiet", underrun_out, 0);
    apb_wr(8'h00, 32'h1);
    probe("underrun1", 8'h21);
    apb_rd(8'h10, rd);
    chk("underrun_sticky", rd & 32'h1, 32'h1);
    apb_wr(8'h10, 32'h1);
    apb_rd(8'h10, rd);
    chk("underrun_w1c", rd & 32'h1, 0);
    probe("underrun2", 8'hE5);

    // randomized stream with a reference model
    apb_wr(8'h10, 32'h3);
    apb_wr(8'h00, 32'h5);
    chk_rd("ctrl_stat_clear_reads0", 8'h00, 32'h1);
    chk_rd("count_cleared", 8'h14, 0);
    exp_count = 0; exp_clip = 1'b0;
    stream_round(120, 16'($urandom_range(0, 511) - 256), 8'($urandom));
    stream_round(120, 16'($urandom), 8'($urandom));
    stream_round(120, 16'hFF00, 8'($urandom_range(0, 15)));
    chk_rd("count_stream", 8'h14, exp_count);
    apb_rd(8'h10, rd);
    chk("clip_stream", rd & 32'h2, exp_clip ? 32'h2 : 32'h0);

    // constant source, then disable
    apb_wr(8'h04, 32'h100);
    apb_wr(8'h08, 32'h0);
    apb_wr(8'h0C, 32'hF0);
    apb_wr(8'h00, 32'h3);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("const_valid", valid_out, 1);
      chk("const_out", out, 8'hF0);
    end
    apb_wr(8'h00, 32'h0);
    @(negedge clk);
    chk("disable_valid", valid_out, 0);
    chk("disable_out", out, 0);

    // LED and unmapped address
    apb_wr(8'h18, 32'h5);
    chk("led_pins", led, 3'd5);
    chk_rd("led_reg", 8'h18, 32'h5);
    apb_wr(8'h1C, 32'hFFFF_FFFF);
    chk_rd("unmapped", 8'h1C, 0);

    // reset with samples in flight
    apb_wr(8'h04, 32'h200);
    apb_wr(8'h00, 32'h1);
    @(negedge clk); din = 8'h01; valid_in = 1'b1;
    @(negedge clk); din = 8'h02;
    @(negedge clk); din = 8'h03;
    @(negedge clk); valid_in = 1'b0;
    chk("flight_valid", valid_out, 1);
    chk("flight_out", out, 8'h02);
    #1 reset = 1'b1;
    #1;
    chk("midrst_out", out, 0);
    chk("midrst_valid", valid_out, 0);
    chk("midrst_underrun", underrun_out, 0);
    chk("midrst_led", led, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postrst_valid", valid_out, 0);
    end
    chk_rd("postrst_gain", 8'h04, 32'h100);
    chk_rd("postrst_ctrl", 8'h00, 0);
    chk_rd("postrst_count", 8'h14, 0);
    chk_rd("postrst_status", 8'h10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
